// File: rtl/timer_ctrl.sv
// Programmable down-count timer with a word-addressed register port.
// Counts PRESET down to zero and raises a maskable interrupt, one-shot or auto-reload.
module timer_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic             pending_q, pending_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic ctrl_wr;
  logic preset_wr;
  logic auto_reload;
  logic hw_en_clr;
  logic pend_set;
  logic pend_clr;
  logic unused_wdata;

  // Unsigned decrement that holds at zero instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? '0 : v - WIDTH'(1);
  endfunction

  assign ctrl_wr      = we && (addr == A_CTRL);
  assign preset_wr    = we && (addr == A_PRESET);
  assign auto_reload  = (mode_q == 2'b01);
  // Upper wdata bits are not stored when WIDTH < 32.
  assign unused_wdata = ^wdata;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hw_en_clr = 1'b0;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q) state_d = LOAD;
      end
      LOAD: begin
        if (!en_q) begin
          state_d = IDLE;
        end else begin
          count_d = preset_q;
          state_d = CNT;
        end
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q <= WIDTH'(1)) begin
          count_d  = '0;
          state_d  = INT;
          pend_set = 1'b1;
        end else begin
          count_d = sat_dec(count_q);
        end
      end
      INT: begin
        if (auto_reload) begin
          pend_clr = 1'b1;
          state_d  = en_q ? LOAD : IDLE;
        end else begin
          hw_en_clr = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus writes beat the one-shot EN clear; a pending set beats any clear.
  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    preset_d  = preset_q;
    pending_d = pending_q;
    if (ctrl_wr) begin
      en_d   = wdata[0];
      mode_d = wdata[2:1];
      im_d   = wdata[3];
    end else if (hw_en_clr) begin
      en_d = 1'b0;
    end
    if (preset_wr) preset_d = wdata[WIDTH-1:0];
    if (ctrl_wr || preset_wr || pend_clr) pending_d = 1'b0;
    if (pend_set) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      mode_q    <= 2'b00;
      im_q      <= 1'b0;
      pending_q <= 1'b0;
      preset_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      pending_q <= pending_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      A_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
      A_PRESET: rdata = 32'(preset_q);
      A_COUNT:  rdata = 32'(count_q);
      default:  rdata = 32'd0;
    endcase
  end

  assign irq = im_q & pending_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios with fixed expectations, then random bus traffic
// compared cycle by cycle against a behavioural model of the timer.
module tb_timer_ctrl;

  localparam int          W    = 8;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  localparam int PH_IDLE = 0;
  localparam int PH_LOAD = 1;
  localparam int PH_CNT  = 2;
  localparam int PH_INT  = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  timer_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model state
  bit          m_en;
  bit          m_im;
  logic [1:0]  m_mode;
  bit          m_pending;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  int          m_phase;

  task automatic model_reset();
    m_en = 0; m_im = 0; m_mode = 2'b00; m_pending = 0;
    m_preset = 0; m_count = 0; m_phase = PH_IDLE;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_irq();
    return m_im & m_pending;
  endfunction

  task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
    int          nph;
    logic [31:0] ncnt;
    bit          set_p;
    bit          clr_p;
    bit          hw_clr;
    nph = m_phase; ncnt = m_count; set_p = 0; clr_p = 0; hw_clr = 0;
    if (m_phase == PH_IDLE) begin
      if (m_en) nph = PH_LOAD;
    end else if (m_phase == PH_LOAD) begin
      if (m_en) begin ncnt = m_preset; nph = PH_CNT; end
      else nph = PH_IDLE;
    end else if (m_phase == PH_CNT) begin
      if (!m_en) nph = PH_IDLE;
      else if (m_count <= 1) begin ncnt = 0; nph = PH_INT; set_p = 1; end
      else ncnt = m_count - 1;
    end else begin
      if (m_mode == 2'b01) begin clr_p = 1; nph = m_en ? PH_LOAD : PH_IDLE; end
      else begin hw_clr = 1; nph = PH_IDLE; end
    end
    if (w && a == 2'd0) begin m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; end
    else if (hw_clr) m_en = 0;
    if (w && (a == 2'd0 || a == 2'd1)) m_pending = 0;
    if (w && a == 2'd1) m_preset = d & MASK;
    if (clr_p) m_pending = 0;
    if (set_p) m_pending = 1;
    m_phase = nph;
    m_count = ncnt;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the bus, advance model and DUT, then compare read data and irq.
  task automatic step(input logic w, input logic [1:0] a, input logic [31:0] d, input string tag);
    we = w; addr = a; wdata = d;
    model_edge(w, a, d);
    @(posedge clk);
    #1;
    we = 1'b0;
    check({tag, " rdata"}, rdata, m_read(a));
    check({tag, " irq"}, {31'd0, irq}, {31'd0, m_irq()});
  endtask

  task automatic cchk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    we = 1'b0; addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic ichk(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    logic        rw;
    logic [1:0]  ra;
    logic [31:0] rd;

    rst_n = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    model_reset();
    @(negedge clk);
    cchk("reset ctrl", 2'd0, 32'd0);
    cchk("reset preset", 2'd1, 32'd0);
    cchk("reset count", 2'd2, 32'd0);
    ichk("reset irq", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a count
    step(1, 2'd1, 32'd9, "t1 preset");
    step(1, 2'd0, 32'h9, "t1 ctrl");
    repeat (4) step(0, 2'd2, 0, "t1 count");
    rst_n = 1'b0;
    model_reset();
    cchk("t1 async ctrl", 2'd0, 32'd0);
    cchk("t1 async count", 2'd2, 32'd0);
    cchk("t1 async preset", 2'd1, 32'd0);
    ichk("t1 async irq", 1'b0);
    #2;
    rst_n = 1'b1;
    repeat (3) step(0, 2'd2, 0, "t1 idle after reset");
    cchk("t1 stays idle", 2'd2, 32'd0);

    // One-shot with interrupt enabled
    step(1, 2'd1, 32'd5, "t2 preset");
    step(1, 2'd0, 32'h9, "t2 ctrl");
    step(0, 2'd2, 0, "t2 load");
    step(0, 2'd2, 0, "t2 cnt");
    cchk("t2 count=N", 2'd2, 32'd5);
    for (int i = 4; i >= 1; i--) begin
      step(0, 2'd2, 0, "t2 dec");
      cchk("t2 count", 2'd2, i);
      ichk("t2 irq low", 1'b0);
    end
    step(0, 2'd2, 0, "t2 expire");
    cchk("t2 count zero", 2'd2, 32'd0);
    ichk("t2 irq rise", 1'b1);
    step(0, 2'd0, 0, "t2 int exit");
    cchk("t2 en cleared", 2'd0, 32'h8);
    ichk("t2 irq held", 1'b1);
    repeat (3) step(0, 2'd0, 0, "t2 hold");
    ichk("t2 irq still held", 1'b1);
    step(1, 2'd0, 32'h0, "t2 ctrl clear");
    ichk("t2 irq cleared", 1'b0);

    // Auto-reload, period change after the next expiry
    step(1, 2'd1, 32'd3, "t3 preset");
    step(1, 2'd0, 32'hB, "t3 ctrl");
    for (int i = 1; i <= 36; i++) begin
      if (i == 17) step(1, 2'd1, 32'd6, "t3 preset rewrite");
      else step(0, 2'd2, 0, "t3 run");
      ichk("t3 irq pattern", (i <= 20) ? (i % 5 == 0) : ((i - 20) % 8 == 0));
      if (i == 2) cchk("t3 count loaded", 2'd2, 32'd3);
      if (i == 6) cchk("t3 count in load", 2'd2, 32'd0);
    end
    step(1, 2'd0, 32'h0, "t3 stop");
    repeat (2) step(0, 2'd2, 0, "t3 settle");

    // Clearing EN freezes the count; re-enabling reloads
    step(1, 2'd1, 32'd4, "t4 preset");
    step(1, 2'd0, 32'h9, "t4 ctrl");
    step(0, 2'd2, 0, "t4 load");
    step(0, 2'd2, 0, "t4 cnt");
    step(0, 2'd2, 0, "t4 dec");
    cchk("t4 count3", 2'd2, 32'd3);
    step(1, 2'd0, 32'h8, "t4 disable");
    repeat (3) step(0, 2'd2, 0, "t4 frozen");
    cchk("t4 count frozen", 2'd2, 32'd2);
    ichk("t4 no irq", 1'b0);
    step(1, 2'd0, 32'h9, "t4 reenable");
    step(0, 2'd2, 0, "t4 reload");
    step(0, 2'd2, 0, "t4 cnt2");
    cchk("t4 reloaded", 2'd2, 32'd4);
    repeat (4) step(0, 2'd2, 0, "t4 run");
    cchk("t4 count zero", 2'd2, 32'd0);
    ichk("t4 irq", 1'b1);

    // Masked interrupt: pending without irq, cleared by the CTRL write
    step(1, 2'd1, 32'd2, "t5 preset");
    step(1, 2'd0, 32'h1, "t5 ctrl");
    for (int i = 0; i < 5; i++) begin
      step(0, 2'd2, 0, "t5 run");
      ichk("t5 irq masked", 1'b0);
    end
    cchk("t5 ctrl en cleared", 2'd0, 32'h0);
    step(1, 2'd0, 32'h8, "t5 unmask");
    ichk("t5 irq after unmask", 1'b0);
    repeat (2) step(0, 2'd0, 0, "t5 idle");
    ichk("t5 irq stays low", 1'b0);

    // PRESET=0 behaves like 1; reserved address and COUNT writes are ignored
    step(1, 2'd1, 32'd0, "t6 preset");
    step(1, 2'd0, 32'h9, "t6 ctrl");
    step(0, 2'd2, 0, "t6 load");
    ichk("t6 irq at load", 1'b0);
    step(0, 2'd2, 0, "t6 cnt");
    ichk("t6 irq at cnt", 1'b0);
    step(0, 2'd2, 0, "t6 int");
    ichk("t6 irq at int", 1'b1);
    cchk("t6 addr3 read", 2'd3, 32'd0);
    step(1, 2'd3, 32'hFFFF_FFFF, "t6 addr3 write");
    ichk("t6 addr3 write keeps pending", 1'b1);
    step(1, 2'd2, 32'h55, "t6 count write");
    cchk("t6 count unchanged", 2'd2, 32'd0);
    cchk("t6 preset unchanged", 2'd1, 32'd0);

    // Simultaneous events: pending set beats a PRESET write, bus CTRL write beats EN clear
    step(1, 2'd1, 32'd2, "t7 preset");
    step(1, 2'd0, 32'h9, "t7 ctrl");
    repeat (3) step(0, 2'd2, 0, "t7 run");
    step(1, 2'd1, 32'h1_02, "t7 preset at expiry");
    ichk("t7 set beats clear", 1'b1);
    cchk("t7 preset truncated", 2'd1, 32'd2);
    step(1, 2'd0, 32'h9, "t7 ctrl at int");
    cchk("t7 bus beats hw clear", 2'd0, 32'h9);
    ichk("t7 pending cleared", 1'b0);
    step(0, 2'd2, 0, "t7 load");
    step(0, 2'd2, 0, "t7 cnt");
    cchk("t7 restarted", 2'd2, 32'd2);
    step(1, 2'd0, 32'h0, "t7 stop");

    // Random bus traffic against the model
    for (int n = 0; n < 400; n++) begin
      rw = ($urandom_range(0, 7) == 0);
      ra = 2'($urandom_range(0, 3));
      rd = $urandom;
      if (ra == 2'd1) rd = (rd & ~MASK) | 32'($urandom_range(0, 6));
      if (ra == 2'd0) rd[0] = ($urandom_range(0, 3) != 0);
      step(rw, ra, rd, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Programmable down-count timer controller. It sequences a WIDTH-bit counter through load, count and terminal-count phases, and raises an interrupt when the count expires. The CPU accesses it as a memory-mapped peripheral through a word-addressed register port. It supports one-shot and auto-reload modes.

Parameters:
WIDTH, 32, bit width of the PRESET and COUNT registers (1..32); narrower values are zero-extended on rdata.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
addr  input  2  register select (word address bits 3:2): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
we  input  1  write strobe; a write is sampled on the rising edge
wdata  input  32  write data
rdata  output  32  combinational read of the register selected by addr
irq  output  1  interrupt request, equal to CTRL.IM AND pending

Behaviour:
- Reset (async, rst_n=0): CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE. Outputs: irq=0, rdata reflects the zeroed registers.
- CTRL bit fields:
  - bit0 EN
  - bits2:1 MODE: 00=one-shot, 01=auto-reload, 1x treated as one-shot
  - bit3 IM (interrupt mask)
  - bits31:4 read as 0
- Write rules:
  - CTRL write sets EN, MODE and IM from wdata[3:0] and clears pending.
  - PRESET write stores wdata[WIDTH-1:0] and clears pending. It does not affect the count in progress; the new value is used at the next LOAD.
  - Writes to COUNT and to addr 3 are ignored. addr 3 reads 0.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1, go to LOAD; otherwise stay. COUNT holds its value.
  - LOAD: COUNT<=PRESET; go to CNT. If EN=0, go to IDLE instead and leave COUNT unchanged.
  - CNT: if EN=0, go to IDLE with COUNT frozen. Else if COUNT<=1, COUNT<=0 and go to INT. Else COUNT<=COUNT-1.
  - INT: pending<=1 on entry, so pending is high during INT.
    - One-shot: hardware clears EN and goes to IDLE. pending stays 1 until the next CTRL or PRESET write.
    - Auto-reload: go to LOAD; pending clears when leaving INT (one-cycle pulse). If EN=0, go to IDLE.
- Timing for PRESET=N≥1, with the EN=1 write at edge t0:
  - Edge t1: enter LOAD.
  - Edge t2: COUNT=N, enter CNT.
  - Edge t2+N: COUNT=0, enter INT, irq rises (if IM=1).
  - PRESET=0 behaves like N=1.
  - Auto-reload period is N+2 cycles, with irq high for 1 cycle per period.
- Simultaneous events:
  - A bus CTRL write in the same cycle as the one-shot hardware EN clear: the bus write wins, so EN takes the written value.
  - A CTRL/PRESET write in the same cycle that pending would be set: the set wins, so pending=1.
- Arithmetic: the decrement is unsigned and never wraps below 0.
- irq is a level output. It is combinational from registered IM and pending, with no extra latency.
- Reset mid-count: returns immediately to the reset values, with no residual irq.

Test Plan:
1. Reset with rst_n=0 asserted asynchronously mid-CNT -> irq=0, COUNT=0, CTRL=0, state IDLE, all without a clock edge.
2. PRESET=5, then CTRL=0x9 (EN, one-shot, IM) -> COUNT=5 two edges after the write, decrements to 0 in 5 edges; irq rises with COUNT=0; EN reads 0 one edge later; irq stays 1 until CTRL=0x0 is written, then 0.
3. PRESET=3, CTRL=0xB (auto-reload, IM) -> irq is a 1-cycle pulse every 5 cycles; COUNT sequence 3,2,1,0,(LOAD)3...; rewriting PRESET=6 mid-count changes the period to 8 starting after the next INT.
4. One-shot, PRESET=4, clear EN (CTRL=0x8) while COUNT=2 -> COUNT frozen at 2, no irq; setting EN again reloads 4 and counts to 0.
5. IM=0, one-shot, PRESET=2 -> pending is set but irq stays 0; then write CTRL=0x8 (IM=1) -> pending is cleared by the write, irq stays 0.
6. PRESET=0, EN set -> INT reached one edge after LOAD; reads of addr 3 return 0 and a write to COUNT has no effect.
